// File: rtl/alu_writeback_pkg.sv
// -----------------------------------------------------------------------------
// alu_writeback_pkg
// Constants shared by the ALU writeback path and any branch logic that
// evaluates the same condition codes.
//   - CC_* : bit positions inside the latched condition-code vector CCN.
//   - wb_cond_e : encodings of the 3-bit per-instruction condition select.
//   - CCN_W / COND_W : widths of the condition-code vector and the selector.
// -----------------------------------------------------------------------------
package alu_writeback_pkg;

    localparam int CCN_W  = 4;
    localparam int COND_W = 3;

    localparam int CC_SIGN   = 0;
    localparam int CC_CARRY  = 1;
    localparam int CC_ZERO   = 2;
    localparam int CC_PARITY = 3;

    typedef enum logic [COND_W-1:0] {
        COND_AL = 3'b000,
        COND_Z  = 3'b001,
        COND_NZ = 3'b010,
        COND_C  = 3'b011,
        COND_NC = 3'b100,
        COND_S  = 3'b101,
        COND_NS = 3'b110,
        COND_P  = 3'b111
    } wb_cond_e;

endpackage

// File: rtl/wb_cond_eval.sv
// -----------------------------------------------------------------------------
// wb_cond_eval
// Purely combinational condition evaluator. Reports whether the selected
// condition holds for the given condition codes.
// Ports:
//   CCN     in  4  condition codes: [0] sign, [1] carry, [2] zero, [3] parity
//   WB_COND in  3  condition select (see wb_cond_e)
//   PASS    out 1  1 when the selected condition is true
// -----------------------------------------------------------------------------
module wb_cond_eval
    import alu_writeback_pkg::*;
(
    input  logic [CCN_W-1:0]  CCN,
    input  logic [COND_W-1:0] WB_COND,
    output logic              PASS
);

    // Decode the condition select against the condition-code bits.
    always_comb begin
        PASS = 1'b0;
        case (wb_cond_e'(WB_COND))
            COND_AL: PASS = 1'b1;
            COND_Z:  PASS = CCN[CC_ZERO];
            COND_NZ: PASS = ~CCN[CC_ZERO];
            COND_C:  PASS = CCN[CC_CARRY];
            COND_NC: PASS = ~CCN[CC_CARRY];
            COND_S:  PASS = CCN[CC_SIGN];
            COND_NS: PASS = ~CCN[CC_SIGN];
            COND_P:  PASS = CCN[CC_PARITY];
            default: PASS = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
// Consumer end of the ALU result path. A conditional write request either
// pushes {dest, result} into a small FIFO that drains to the register-file
// write port, or is squashed (COND_FAIL pulse). Pending entries are forwarded
// back to the operand muxes so they see results before the register file does.
// Ports:
//   CLK, RESET             clock; synchronous active-low reset
//   ALU_R, CCN             ALU result and latched condition codes
//   WB_ISSUE/DEST/COND     single-cycle write request, destination, condition
//   RF_ACK                 register file consumed the head entry
//   RF_WE/WADDR/WDATA      head entry (valid, destination, data)
//   WB_STALL               queue full, upstream must hold the request
//   COND_FAIL              one-cycle pulse after a squashed request
//   FWD_A_X / FWD_B_X      operand register indices to look up
//   FWD_x_HIT / FWD_x_DATA youngest pending entry matching that index
// -----------------------------------------------------------------------------
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] ALU_R,
    input  logic [CCN_W-1:0]  CCN,
    input  logic              WB_ISSUE,
    input  logic [REG_W-1:0]  WB_DEST,
    input  logic [COND_W-1:0] WB_COND,
    input  logic              RF_ACK,
    output logic              RF_WE,
    output logic [REG_W-1:0]  RF_WADDR,
    output logic [DATA_W-1:0] RF_WDATA,
    output logic              WB_STALL,
    output logic              COND_FAIL,
    input  logic [REG_W-1:0]  FWD_A_X,
    input  logic [REG_W-1:0]  FWD_B_X,
    output logic              FWD_A_HIT,
    output logic [DATA_W-1:0] FWD_A_DATA,
    output logic              FWD_B_HIT,
    output logic [DATA_W-1:0] FWD_B_DATA
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [REG_W-1:0]  dest_r [DEPTH];
    logic [DATA_W-1:0] data_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              cond_fail_r;

    logic pass_s;
    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic squash_s;

    wb_cond_eval u_cond (
        .CCN     (CCN),
        .WB_COND (WB_COND),
        .PASS    (pass_s)
    );

    // Queue occupancy flags and the push / pop / squash decisions for this cycle.
    always_comb begin
        full_s   = (count_r == FULL_CNT);
        empty_s  = (count_r == {CNT_W{1'b0}});
        push_s   = WB_ISSUE & pass_s & ~full_s;
        pop_s    = RF_ACK & ~empty_s;
        // A failing condition is consumed even when the queue is full.
        squash_s = WB_ISSUE & ~pass_s;
    end

    // FIFO storage, pointers, occupancy and the squash pulse register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            cond_fail_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_r[i] <= {REG_W{1'b0}};
                data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            cond_fail_r <= squash_s;
            if (push_s) begin
                dest_r[tail_r] <= WB_DEST;
                data_r[tail_r] <= ALU_R;
                // DEPTH is a power of two, so natural overflow wraps the pointer.
                tail_r         <= tail_r + 1'b1;
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + 1'b1;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register-file write port and status outputs, all decoded from state.
    always_comb begin
        RF_WE     = ~empty_s;
        WB_STALL  = full_s;
        COND_FAIL = cond_fail_r;
        if (empty_s) begin
            RF_WADDR = {REG_W{1'b0}};
            RF_WDATA = {DATA_W{1'b0}};
        end else begin
            RF_WADDR = dest_r[head_r];
            RF_WDATA = data_r[head_r];
        end
    end

    // Forwarding scan: walk valid entries oldest to youngest so the youngest
    // match overwrites older ones. Same-cycle pushes are not yet in storage.
    always_comb begin
        FWD_A_HIT  = 1'b0;
        FWD_A_DATA = {DATA_W{1'b0}};
        FWD_B_HIT  = 1'b0;
        FWD_B_DATA = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            FWD_A_HIT  = ((CNT_W'(i) < count_r) && (dest_r[head_r + PTR_W'(i)] == FWD_A_X))
                         ? 1'b1 : FWD_A_HIT;
            FWD_A_DATA = ((CNT_W'(i) < count_r) && (dest_r[head_r + PTR_W'(i)] == FWD_A_X))
                         ? data_r[head_r + PTR_W'(i)] : FWD_A_DATA;
            FWD_B_HIT  = ((CNT_W'(i) < count_r) && (dest_r[head_r + PTR_W'(i)] == FWD_B_X))
                         ? 1'b1 : FWD_B_HIT;
            FWD_B_DATA = ((CNT_W'(i) < count_r) && (dest_r[head_r + PTR_W'(i)] == FWD_B_X))
                         ? data_r[head_r + PTR_W'(i)] : FWD_B_DATA;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// -----------------------------------------------------------------------------
// tb_alu_writeback
// Directed scenarios with literal expectations, followed by randomized traffic.
// A queue-based reference model is updated at every rising edge and compared
// against all DUT outputs on every falling edge once reset has been seen.
// -----------------------------------------------------------------------------
module tb_alu_writeback;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [DATA_W-1:0] ALU_R;
    logic [3:0]        CCN;
    logic              WB_ISSUE;
    logic [REG_W-1:0]  WB_DEST;
    logic [2:0]        WB_COND;
    logic              RF_ACK;
    logic              RF_WE;
    logic [REG_W-1:0]  RF_WADDR;
    logic [DATA_W-1:0] RF_WDATA;
    logic              WB_STALL;
    logic              COND_FAIL;
    logic [REG_W-1:0]  FWD_A_X;
    logic [REG_W-1:0]  FWD_B_X;
    logic              FWD_A_HIT;
    logic [DATA_W-1:0] FWD_A_DATA;
    logic              FWD_B_HIT;
    logic [DATA_W-1:0] FWD_B_DATA;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   cf_m  = 1'b0;
    bit   armed = 1'b0;

    always #5 CLK = ~CLK;

    alu_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ALU_R      (ALU_R),
        .CCN        (CCN),
        .WB_ISSUE   (WB_ISSUE),
        .WB_DEST    (WB_DEST),
        .WB_COND    (WB_COND),
        .RF_ACK     (RF_ACK),
        .RF_WE      (RF_WE),
        .RF_WADDR   (RF_WADDR),
        .RF_WDATA   (RF_WDATA),
        .WB_STALL   (WB_STALL),
        .COND_FAIL  (COND_FAIL),
        .FWD_A_X    (FWD_A_X),
        .FWD_B_X    (FWD_B_X),
        .FWD_A_HIT  (FWD_A_HIT),
        .FWD_A_DATA (FWD_A_DATA),
        .FWD_B_HIT  (FWD_B_HIT),
        .FWD_B_DATA (FWD_B_DATA)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic issue(input logic [REG_W-1:0] d, input logic [DATA_W-1:0] v,
                         input logic [2:0] c, input logic [3:0] cc);
        WB_ISSUE = 1'b1;
        WB_DEST  = d;
        ALU_R    = v;
        WB_COND  = c;
        CCN      = cc;
    endtask

    function automatic bit cond_true(input logic [2:0] c, input logic [3:0] cc);
        // cc: [0] sign, [1] carry, [2] zero, [3] parity
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return cc[2];
            3'd2:    return !cc[2];
            3'd3:    return cc[1];
            3'd4:    return !cc[1];
            3'd5:    return cc[0];
            3'd6:    return !cc[0];
            default: return cc[3];
        endcase
    endfunction

    // Reference model update at each rising edge, comparison at each falling edge.
    initial begin
        forever begin
            @(posedge CLK);
            if (!RESET) begin
                q.delete();
                cf_m  = 1'b0;
                armed = 1'b1;
            end else if (armed) begin
                int  sz;
                bit  p;
                p    = cond_true(WB_COND, CCN);
                sz   = q.size();
                cf_m = WB_ISSUE && !p;
                if (RF_ACK && sz > 0) void'(q.pop_front());
                if (WB_ISSUE && p && sz < DEPTH) q.push_back(ent_t'({WB_DEST, ALU_R}));
            end
            @(negedge CLK);
            if (armed) begin
                bit                ha, hb;
                logic [DATA_W-1:0] da, db;
                ha = 1'b0; hb = 1'b0; da = '0; db = '0;
                foreach (q[k]) begin
                    if (q[k].dest == FWD_A_X) begin ha = 1'b1; da = q[k].data; end
                    if (q[k].dest == FWD_B_X) begin hb = 1'b1; db = q[k].data; end
                end
                chk("m_rf_we",     RF_WE,     (q.size() != 0));
                chk("m_rf_waddr",  RF_WADDR,  (q.size() != 0) ? q[0].dest : '0);
                chk("m_rf_wdata",  RF_WDATA,  (q.size() != 0) ? q[0].data : '0);
                chk("m_wb_stall",  WB_STALL,  (q.size() == DEPTH));
                chk("m_cond_fail", COND_FAIL, cf_m);
                chk("m_fwd_a_hit", FWD_A_HIT, ha);
                chk("m_fwd_a_dat", FWD_A_DATA, da);
                chk("m_fwd_b_hit", FWD_B_HIT, hb);
                chk("m_fwd_b_dat", FWD_B_DATA, db);
            end
        end
    end

    initial begin
        RESET = 1'b0; ALU_R = '0; CCN = '0; WB_ISSUE = 1'b0; WB_DEST = '0;
        WB_COND = '0; RF_ACK = 1'b0; FWD_A_X = '0; FWD_B_X = '0;

        // Initial reset
        tick(); tick();
        @(negedge CLK);
        chk("rst_we", RF_WE, 0); chk("rst_stall", WB_STALL, 0); chk("rst_cf", COND_FAIL, 0);
        chk("rst_waddr", RF_WADDR, 0); chk("rst_wdata", RF_WDATA, 0);
        tick(); RESET = 1'b1;

        // Squash: Z=1 with NZ condition
        issue(4'd3, 16'h1234, 3'b010, 4'b0100);
        tick(); WB_ISSUE = 1'b0;
        @(negedge CLK);
        chk("sq_cf", COND_FAIL, 1); chk("sq_we", RF_WE, 0);
        tick();
        @(negedge CLK);
        chk("sq_cf_off", COND_FAIL, 0); chk("sq_we2", RF_WE, 0);
        // Same request with Z condition passes
        tick(); issue(4'd3, 16'h1234, 3'b001, 4'b0100);
        tick(); WB_ISSUE = 1'b0;
        @(negedge CLK);
        chk("z_we", RF_WE, 1); chk("z_waddr", RF_WADDR, 3); chk("z_wdata", RF_WDATA, 16'h1234);
        chk("z_cf", COND_FAIL, 0);
        tick(); RF_ACK = 1'b1;
        tick(); RF_ACK = 1'b0;
        @(negedge CLK);
        chk("z_drained", RF_WE, 0);

        // Backpressure
        tick(); issue(4'd1, 16'hAAAA, 3'b000, 4'b0000);
        tick(); issue(4'd2, 16'hBBBB, 3'b000, 4'b0000);
        tick(); issue(4'd5, 16'hCCCC, 3'b000, 4'b0000);
        @(negedge CLK);
        chk("bp_stall", WB_STALL, 1); chk("bp_head_a", RF_WADDR, 1);
        tick(); WB_ISSUE = 1'b0;
        @(negedge CLK);
        chk("bp_stall2", WB_STALL, 1); chk("bp_hold_a", RF_WDATA, 16'hAAAA);
        tick(); RF_ACK = 1'b1;
        tick();
        @(negedge CLK);
        chk("bp_head_b", RF_WADDR, 2); chk("bp_data_b", RF_WDATA, 16'hBBBB);
        chk("bp_nostall", WB_STALL, 0);
        tick(); RF_ACK = 1'b0;
        @(negedge CLK);
        chk("bp_empty", RF_WE, 0);

        // Forwarding priority
        tick(); issue(4'd4, 16'h0011, 3'b000, 4'b0000); FWD_A_X = 4'd4; FWD_B_X = 4'd7;
        tick(); issue(4'd4, 16'h0022, 3'b000, 4'b0000);
        @(negedge CLK);
        chk("fw_old", FWD_A_DATA, 16'h0011);
        tick(); WB_ISSUE = 1'b0;
        @(negedge CLK);
        chk("fw_a_hit", FWD_A_HIT, 1); chk("fw_a_dat", FWD_A_DATA, 16'h0022);
        chk("fw_b_hit", FWD_B_HIT, 0); chk("fw_b_dat", FWD_B_DATA, 0);
        tick(); RF_ACK = 1'b1;

        // Simultaneous push/pop across pointer wrap
        for (int n = 0; n < 8; n++) begin
            tick(); issue(REG_W'(n + 8), 16'h5000 + 16'(n), 3'b000, 4'b0000);
            @(negedge CLK);
            chk("pp_waddr", RF_WADDR, (n == 0) ? 4 : n + 7);
            chk("pp_wdata", RF_WDATA, (n == 0) ? 16'h0022 : 16'h5000 + 16'(n - 1));
            chk("pp_stall", WB_STALL, 0);
        end
        tick(); WB_ISSUE = 1'b0;
        @(negedge CLK);
        chk("pp_last", RF_WDATA, 16'h5007);
        tick(); RF_ACK = 1'b0;
        @(negedge CLK);
        chk("pp_empty", RF_WE, 0);

        // Reset mid-drain
        tick(); issue(4'd6, 16'h1111, 3'b000, 4'b0000);
        tick(); issue(4'd9, 16'h2222, 3'b000, 4'b0000);
        tick(); WB_ISSUE = 1'b0; FWD_A_X = 4'd6;
        @(negedge CLK);
        chk("rd_full", WB_STALL, 1); chk("rd_fwd", FWD_A_HIT, 1);
        tick(); RESET = 1'b0; RF_ACK = 1'b1;
        tick();
        @(negedge CLK);
        chk("rd_we", RF_WE, 0); chk("rd_stall", WB_STALL, 0); chk("rd_fwd_clr", FWD_A_HIT, 0);
        tick(); RESET = 1'b1; RF_ACK = 1'b0;
        @(negedge CLK);
        chk("rd_after", RF_WE, 0);
        tick();
        @(negedge CLK);
        chk("rd_after2", RF_WE, 0);

        // Randomized traffic, checked by the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            RESET    = ($urandom_range(0, 99) != 0);
            WB_ISSUE = 1'($urandom_range(0, 1));
            WB_DEST  = REG_W'($urandom_range(0, 7));
            WB_COND  = 3'($urandom_range(0, 7));
            CCN      = 4'($urandom);
            ALU_R    = 16'($urandom);
            RF_ACK   = ($urandom_range(0, 2) == 0);
            FWD_A_X  = REG_W'($urandom_range(0, 7));
            FWD_B_X  = REG_W'($urandom_range(0, 7));
        end
        tick(); WB_ISSUE = 1'b0; RF_ACK = 1'b0;
        @(negedge CLK);
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Consumer end of the ALU result path: takes ALU_R and the latched condition codes from the full ALU.
- Applies a per-instruction condition to the result, then queues it in a small FIFO toward the register-file write port, with a valid/ack handshake.
- Forwards pending, not-yet-written results back to the ALU operand side, so operand muxes see fresh data before the register file is updated.

Parameters:
- DEPTH, 2, number of queued writeback entries (power of two, 2..4).
- DATA_W, 16, result width.
- REG_W, 4, register index width (matches ARGA_X/ARGB_X).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  synchronous, active-low reset.
- ALU_R  in  DATA_W  ALU result.
- CCN  in  4  latched CCs: [0] sign, [1] carry, [2] zero, [3] parity.
- WB_ISSUE  in  1  single-cycle request to write ALU_R.
- WB_DEST  in  REG_W  destination register index.
- WB_COND  in  3  condition select.
- RF_ACK  in  1  register file accepted head entry this cycle.
- RF_WE  out  1  head entry valid (write request).
- RF_WADDR  out  REG_W  head destination.
- RF_WDATA  out  DATA_W  head data.
- WB_STALL  out  1  queue full; upstream holds WB_ISSUE and its operands.
- COND_FAIL  out  1  one-cycle pulse: issued write squashed by condition.
- FWD_A_X  in  REG_W  register index currently selected for operand A.
- FWD_B_X  in  REG_W  register index currently selected for operand B.
- FWD_A_HIT  out  1  a pending entry matches FWD_A_X.
- FWD_A_DATA  out  DATA_W  data of the matching entry for A.
- FWD_B_HIT  out  1  a pending entry matches FWD_B_X.
- FWD_B_DATA  out  DATA_W  data of the matching entry for B.

Behaviour:
- Reset (RESET=0 at a rising edge):
  - Queue emptied, pointers and count to 0.
  - COND_FAIL=0, RF_WE=0, WB_STALL=0, FWD_*_HIT=0.
  - RF_WADDR, RF_WDATA, FWD_*_DATA = 0.
  - Reset mid-operation discards all pending entries; no write is emitted.
- Condition evaluation is combinational on the CCN present in the WB_ISSUE cycle:
  - 000 always; 001 Z=1; 010 Z=0; 011 C=1; 100 C=0; 101 S=1; 110 S=0; 111 P=1.
- Push, when WB_ISSUE=1, condition true and count<DEPTH:
  - {WB_DEST, ALU_R} written at the tail; count+1 next cycle.
- Squash, when WB_ISSUE=1 and condition false:
  - No push; COND_FAIL=1 in the following cycle only.
  - A squash is accepted even when the queue is full.
- WB_STALL=1 exactly when count==DEPTH (registered-state only; no combinational path from RF_ACK).
  - WB_ISSUE with a true condition while WB_STALL=1 is ignored; upstream must re-present it.
- Drain:
  - RF_WE=1 whenever count>0; RF_WADDR/RF_WDATA show the head, stable until acknowledged.
  - RF_ACK=1 with RF_WE=1 pops the head at the edge.
  - RF_ACK while empty is ignored.
- Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: issue to RF_WE=1 is one cycle when the queue was empty.
- Forwarding is combinational over valid entries:
  - HIT=1 if any valid entry's dest equals FWD_x_X.
  - With several matches, the youngest (closest to tail) wins.
  - Entries being pushed in the same cycle are not visible until the next cycle.
  - The entry being popped in the same cycle is still visible.
  - With no hit, DATA=0.
- Register 0 gets no special treatment.

Decomposition:
- Shared constants file holds:
  - CC bit positions (SIGN=0, CARRY=1, ZERO=2, PARITY=3).
  - WB_COND encodings (COND_AL, COND_Z, COND_NZ, COND_C, COND_NC, COND_S, COND_NS, COND_P).
- One sub-module: wb_cond_eval (CCN, WB_COND -> pass), purely combinational, reusable by branch logic.
- FIFO storage, pointers and the forwarding priority scan stay in alu_writeback.

Test Plan:
- Reset: hold RESET=0 for 2 cycles with RF_WE previously 1 -> RF_WE=0, WB_STALL=0, count 0; no write after release.
- Conditional squash: CCN=4'b0100, WB_COND=010 (NZ), WB_ISSUE, ALU_R=16'h1234, dest 3 -> COND_FAIL pulse 1 cycle, RF_WE stays 0. Repeat with 001 (Z) -> RF_WE=1, RF_WADDR=3, RF_WDATA=16'h1234 next cycle.
- Backpressure: RF_ACK=0, issue dest 1 data 16'hAAAA then dest 2 data 16'hBBBB (COND_AL) -> WB_STALL=1. Third issue (dest 5, 16'hCCCC) ignored. Then RF_ACK=1 for 2 cycles -> writes (1,AAAA), (2,BBBB) in order, then RF_WE=0.
- Simultaneous push/pop: count=1, RF_ACK=1 and WB_ISSUE same cycle -> count stays 1, head becomes the new entry; repeat 8 times to cross pointer wrap with no loss or duplication.
- Forwarding priority: queue holds (dest 4, 16'h0011) then (dest 4, 16'h0022); FWD_A_X=4 -> FWD_A_HIT=1, DATA=16'h0022. FWD_B_X=7 -> FWD_B_HIT=0, DATA=0.
- Reset mid-drain: queue full, assert RESET=0 during RF_ACK -> next cycle RF_WE=0, WB_STALL=0; forwarding hits cleared.
